// File: rtl/buffet_rmw_ctrl.sv
// rtl/buffet_rmw_ctrl.sv - buffet read / read-modify-write / shrink sequencer
// Runs one READ, ACCUM or SHRINK command at a time against a single buffet.
module buffet_rmw_ctrl #(
    parameter int IDX_WIDTH  = 8,
    parameter int DATA_WIDTH = 32,
    parameter bit SATURATE   = 1'b0
) (
    input  logic                  clk,
    input  logic                  nreset_i,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [IDX_WIDTH-1:0]  cmd_idx,
    input  logic [DATA_WIDTH-1:0] cmd_operand,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [IDX_WIDTH-1:0]  buf_read_idx,
    output logic                  buf_read_idx_valid,
    input  logic                  buf_read_idx_ready,
    output logic                  buf_read_will_update,
    output logic                  buf_is_shrink,
    input  logic [DATA_WIDTH-1:0] buf_read_data,
    input  logic                  buf_read_data_valid,
    output logic                  buf_read_data_ready,
    output logic [IDX_WIDTH-1:0]  buf_update_idx,
    output logic [DATA_WIDTH-1:0] buf_update_data,
    output logic                  buf_update_valid,
    input  logic                  buf_update_ready,
    input  logic                  buf_update_ack,
    output logic                  busy
);

    localparam logic [1:0] OP_READ   = 2'd0;
    localparam logic [1:0] OP_ACCUM  = 2'd1;
    localparam logic [1:0] OP_SHRINK = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_UPD_REQ = 3'd3,
        S_UPD_ACK = 3'd4,
        S_RSP     = 3'd5,
        S_SHR_REQ = 3'd6
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              op_q, op_d;
    logic [IDX_WIDTH-1:0]    idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   operand_q, operand_d;

    logic                    rd_idx_valid_q, rd_idx_valid_d;
    logic [IDX_WIDTH-1:0]    rd_idx_q, rd_idx_d;
    logic                    will_update_q, will_update_d;
    logic                    is_shrink_q, is_shrink_d;
    logic                    rd_data_ready_q, rd_data_ready_d;
    logic                    upd_valid_q, upd_valid_d;
    logic [IDX_WIDTH-1:0]    upd_idx_q, upd_idx_d;
    logic [DATA_WIDTH-1:0]   upd_data_q, upd_data_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;

    logic                    cmd_hs;
    logic [1:0]              cmd_op_norm;
    logic [1:0]              eff_op;
    logic [DATA_WIDTH:0]     sum_ext;
    logic [DATA_WIDTH-1:0]   sum;

    // Reserved opcode 3 behaves exactly like READ.
    assign cmd_op_norm = (cmd_op == 2'd3) ? OP_READ : cmd_op;
    assign cmd_hs      = cmd_valid && (state_q == S_IDLE);
    assign eff_op      = cmd_hs ? cmd_op_norm : op_q;

    assign sum_ext = {1'b0, buf_read_data} + {1'b0, operand_q};
    assign sum     = (SATURATE && sum_ext[DATA_WIDTH]) ? {DATA_WIDTH{1'b1}}
                                                       : sum_ext[DATA_WIDTH-1:0];

    always_ff @(posedge clk or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = (cmd_op_norm == OP_SHRINK) ? S_SHR_REQ : S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                if (buf_read_idx_ready) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (buf_read_data_valid) state_d = (op_q == OP_ACCUM) ? S_UPD_REQ : S_RSP;
            end
            S_UPD_REQ: begin
                if (buf_update_ready) state_d = buf_update_ack ? S_RSP : S_UPD_ACK;
            end
            S_UPD_ACK: begin
                if (buf_update_ack) state_d = S_RSP;
            end
            S_RSP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            S_SHR_REQ: begin
                if (buf_read_idx_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are precomputed from the next state so that every buffet-facing
    // signal leaves a flop.
    always_comb begin
        op_d            = cmd_hs ? cmd_op_norm : op_q;
        idx_d           = cmd_hs ? cmd_idx     : idx_q;
        operand_d       = cmd_hs ? cmd_operand : operand_q;

        rd_idx_valid_d  = (state_d == S_RD_REQ) || (state_d == S_SHR_REQ);
        rd_idx_d        = cmd_hs ? cmd_idx : rd_idx_q;
        will_update_d   = (state_d == S_RD_REQ) && (eff_op == OP_ACCUM);
        is_shrink_d     = (state_d == S_SHR_REQ);
        rd_data_ready_d = (state_d == S_RD_WAIT);
        upd_valid_d     = (state_d == S_UPD_REQ);
        rsp_valid_d     = (state_d == S_RSP);

        upd_idx_d       = upd_idx_q;
        upd_data_d      = upd_data_q;
        rsp_data_d      = rsp_data_q;
        if (state_q == S_RD_WAIT && buf_read_data_valid) begin
            rsp_data_d = buf_read_data;
            if (op_q == OP_ACCUM) begin
                upd_idx_d  = idx_q;
                upd_data_d = sum;
            end
        end
    end

    always_ff @(posedge clk or negedge nreset_i) begin
        if (!nreset_i) begin
            op_q            <= OP_READ;
            idx_q           <= '0;
            operand_q       <= '0;
            rd_idx_valid_q  <= 1'b0;
            rd_idx_q        <= '0;
            will_update_q   <= 1'b0;
            is_shrink_q     <= 1'b0;
            rd_data_ready_q <= 1'b0;
            upd_valid_q     <= 1'b0;
            upd_idx_q       <= '0;
            upd_data_q      <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_data_q      <= '0;
        end else begin
            op_q            <= op_d;
            idx_q           <= idx_d;
            operand_q       <= operand_d;
            rd_idx_valid_q  <= rd_idx_valid_d;
            rd_idx_q        <= rd_idx_d;
            will_update_q   <= will_update_d;
            is_shrink_q     <= is_shrink_d;
            rd_data_ready_q <= rd_data_ready_d;
            upd_valid_q     <= upd_valid_d;
            upd_idx_q       <= upd_idx_d;
            upd_data_q      <= upd_data_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_data_q      <= rsp_data_d;
        end
    end

    assign cmd_ready            = (state_q == S_IDLE);
    assign busy                 = (state_q != S_IDLE);
    assign rsp_valid            = rsp_valid_q;
    assign rsp_data             = rsp_data_q;
    assign buf_read_idx         = rd_idx_q;
    assign buf_read_idx_valid   = rd_idx_valid_q;
    assign buf_read_will_update = will_update_q;
    assign buf_is_shrink        = is_shrink_q;
    assign buf_read_data_ready  = rd_data_ready_q;
    assign buf_update_idx       = upd_idx_q;
    assign buf_update_data      = upd_data_q;
    assign buf_update_valid     = upd_valid_q;

endmodule
